// File: rtl/sum_latch_uart_pkg.sv
// Shared FSM encoding and byte-count helper for the sum/latch UART transmitter.
package sum_latch_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   function automatic int nbytes(input int bits);
      return (bits + 7) / 8;
   endfunction

endpackage

// File: rtl/uart_tx_core.sv
// Per-byte UART serializer: start, 8 data bits LSB first, optional even parity, stop.
// txd/busy registered; a new byte is accepted in IDLE or at the final stop-bit cycle (o_load).
module uart_tx_core
   import sum_latch_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int PARITY_EN    = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_start,
   input  logic       i_more,
   input  logic [7:0] i_byte,
   output logic       o_load,
   output logic       o_txd,
   output logic       o_busy
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   tx_state_t        r_state;
   logic [CNT_W-1:0] r_baud;
   logic [2:0]       r_bit;
   logic [7:0]       r_shift;
   logic             r_par;
   logic             r_txd;
   logic             r_busy;
   logic             w_bit_end;
   logic             w_load;

   assign w_bit_end = (r_baud == CNT_MAX);
   // Loading straight out of STOP keeps consecutive bytes gap-free.
   assign w_load = ((r_state == IDLE) && i_start) ||
                   ((r_state == STOP) && w_bit_end && i_more);
   assign o_load = w_load;
   assign o_txd  = r_txd;
   assign o_busy = r_busy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_txd   <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         if ((r_state == IDLE) || w_bit_end) r_baud <= '0;
         else r_baud <= r_baud + CNT_W'(1);

         if (w_load) begin
            r_state <= START;
            r_txd   <= 1'b0;
            r_busy  <= 1'b1;
            r_shift <= i_byte;
            r_par   <= ^i_byte;
            r_bit   <= '0;
         end else if (w_bit_end) begin
            case (r_state)
               START: begin
                  r_state <= DATA;
                  r_txd   <= r_shift[0];
                  r_shift <= {1'b0, r_shift[7:1]};
               end
               DATA: begin
                  if (r_bit == 3'd7) begin
                     r_state <= (PARITY_EN != 0) ? PARITY : STOP;
                     r_txd   <= (PARITY_EN != 0) ? r_par : 1'b1;
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_txd   <= r_shift[0];
                     r_shift <= {1'b0, r_shift[7:1]};
                  end
               end
               PARITY: begin
                  r_state <= STOP;
                  r_txd   <= 1'b1;
               end
               default: begin
                  r_state <= IDLE;
                  r_txd   <= 1'b1;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/sum_latch_uart_tx.sv
// Latches two operands, registers A+B or A-B every cycle, and ships the result over UART on request.
// Result latency 1 cycle; tx requests while busy are dropped, never queued.
module sum_latch_uart_tx
   import sum_latch_uart_pkg::*;
#(
   parameter int DATA_W       = 4,
   parameter int CLKS_PER_BIT = 104,
   parameter int PARITY_EN    = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              save_a_n,
   input  logic              save_b_n,
   input  logic              op_sub,
   input  logic              uart_tx_en,
   output logic [DATA_W:0]   result,
   output logic              uart_txd,
   output logic              uart_busy
);
   localparam int RES_W  = DATA_W + 1;
   localparam int NBYTES = nbytes(RES_W);
   localparam int PAD_W  = NBYTES * 8;
   localparam int LEFT_W = $clog2(NBYTES + 1);

   // [1:0] synchronizer, [2] history
   logic [2:0]        r_sa_sync;
   logic [2:0]        r_sb_sync;
   logic [2:0]        r_tx_sync;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [DATA_W:0]   r_result;
   logic              r_res_sub;
   logic [PAD_W-1:0]  r_snap;
   logic [LEFT_W-1:0] r_left;

   logic              w_load_a;
   logic              w_load_b;
   logic              w_tx_rise;
   logic              w_go;
   logic              w_load;
   logic              w_more;
   logic              w_busy;
   logic              w_txd;
   logic [7:0]        w_byte;
   logic [PAD_W-1:0]  w_pad;

   assign w_load_a  = r_sa_sync[2] & ~r_sa_sync[1];
   assign w_load_b  = r_sb_sync[2] & ~r_sb_sync[1];
   assign w_tx_rise = r_tx_sync[1] & ~r_tx_sync[2];
   assign w_go      = w_tx_rise & ~w_busy;
   assign w_more    = (r_left != '0);
   assign w_byte    = w_busy ? r_snap[7:0] : w_pad[7:0];

   assign result    = r_result;
   assign uart_txd  = w_txd;
   assign uart_busy = w_busy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sa_sync <= '1;
         r_sb_sync <= '1;
         r_tx_sync <= '0;
      end else begin
         r_sa_sync <= {r_sa_sync[1:0], save_a_n};
         r_sb_sync <= {r_sb_sync[1:0], save_b_n};
         r_tx_sync <= {r_tx_sync[1:0], uart_tx_en};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a       <= '0;
         r_b       <= '0;
         r_result  <= '0;
         r_res_sub <= 1'b0;
      end else begin
         if (w_load_a) r_a <= data_in;
         if (w_load_b) r_b <= data_in;
         r_res_sub <= op_sub;
         r_result  <= op_sub ? ({1'b0, r_a} - {1'b0, r_b})
                             : ({1'b0, r_a} + {1'b0, r_b});
      end
   end

   // Padding follows the mode that produced the registered result.
   always_comb begin
      w_pad = PAD_W'(r_result);
      if (r_res_sub) begin
         for (int i = RES_W; i < PAD_W; i++) w_pad[i] = r_result[DATA_W];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_snap <= '0;
         r_left <= '0;
      end else if (w_go) begin
         r_snap <= w_pad >> 8;
         r_left <= LEFT_W'(NBYTES - 1);
      end else if (w_load) begin
         r_snap <= r_snap >> 8;
         r_left <= r_left - LEFT_W'(1);
      end
   end

   uart_tx_core #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .PARITY_EN    (PARITY_EN)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .i_start (w_go),
      .i_more  (w_more),
      .i_byte  (w_byte),
      .o_load  (w_load),
      .o_txd   (w_txd),
      .o_busy  (w_busy)
   );

endmodule
